// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// scan state encoding, active-low hex segment codes and segment bit positions.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Bit positions inside the 8-bit segment drive word
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // All seven segments dark (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low g..a patterns for hex digits 0-F (index = nibble value)
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_decode.sv
// Combinational hex nibble to active-low 7-segment (g..a) decoder.
// A single instance is time-shared across all digits by the scan controller.
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for the current nibble
  always_comb begin
    seg_o = SEG_CODE[nibble_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display scan controller with double-buffered writes.
// Optional build macro SEG_LEADING_BLANK_EN: when defined, leading zero digits
// (all more-significant nibbles zero, never digit 0) are blanked.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  input  logic [4*DIGITS-1:0]   wr_data,
  output logic                  wr_ready,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int DW = 4 * DIGITS;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic [DW-1:0]   pend_q, pend_d;
  logic            pendValid_q, pendValid_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]      seg_q, seg_d;

  logic            tick;
  logic            lastDigit;
  logic            frameDone;
  logic            accept;
  logic            commit;
  logic [3:0]      curNibble;
  logic [6:0]      decSeg;
  logic            leadBlank;

  assign tick       = (state_q == SCAN) && (presc_q == PW'(DIV - 1));
  assign lastDigit  = (idx_q == IW'(DIGITS - 1));
  assign frameDone  = tick && lastDigit;
  assign frame_done = frameDone;
  assign wr_ready   = ~pendValid_q;
  assign sel        = sel_q;
  assign seg        = seg_q;

  // Scan state follows the enable input one clock later
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = SCAN;
      SCAN:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Prescaler and digit index run only while staying in SCAN, else park at 0
  always_comb begin
    presc_d = '0;
    idx_d   = '0;
    if (state_q == SCAN && state_d == SCAN) begin
      if (tick) begin
        presc_d = '0;
        idx_d   = lastDigit ? '0 : idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
      end
    end
  end

  // Double buffer: accept into pending, commit at frame end (SCAN) or at once (IDLE)
  always_comb begin
    accept      = wr_valid && !pendValid_q;
    commit      = pendValid_q && ((state_q == IDLE) || frameDone);
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    disp_d      = disp_q;
    if (commit) begin
      disp_d      = pend_q;
      pendValid_d = 1'b0;
    end else if (accept) begin
      pend_d      = wr_data;
      pendValid_d = 1'b1;
    end
  end

  // Select the nibble of the digit currently being scanned
  always_comb begin
    curNibble = disp_q[4*int'(idx_q) +: 4];
  end

  seg_hex_decode u_hexDecode (
    .nibble_i (curNibble),
    .seg_o    (decSeg)
  );

`ifdef SEG_LEADING_BLANK_EN
  logic [DW-1:0] upperNibbles;

  // Blank a non-zero-position digit when it and everything above it are zero
  always_comb begin
    upperNibbles = disp_q >> (4 * int'(idx_q));
    leadBlank    = (idx_q != '0) && (upperNibbles == '0);
  end
`else
  // Leading-zero blanking is not built: every digit is decoded
  always_comb begin
    leadBlank = 1'b0;
  end
`endif

  // Next registered digit drive; dark whenever not actively scanning
  always_comb begin
    sel_d = '1;
    seg_d = 8'hFF;
    if (state_q == SCAN && en) begin
      sel_d                = ~(DIGITS'(1) << idx_q);
      seg_d[SEG_DP]        = ~dp_mask[idx_q];
      seg_d[SEG_G:SEG_A]   = leadBlank ? SEG_BLANK : decSeg;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, buffers and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pendValid_q <= 1'b0;
      sel_q       <= '1;
      seg_q       <= 8'hFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

endmodule
